// File: rtl/xup_debounce5_if.sv
// Five-channel button bundle shared by the debouncer and whatever drives it.
// Raw inputs flow master -> slave; debounced levels and edge pulses flow back.
interface xup_debounce5_if;
  logic [4:0] btn_in;   // raw asynchronous inputs, bit i = channel i
  logic [4:0] btn_out;  // debounced levels, bit0 = OR input a .. bit4 = OR input e
  logic [4:0] rise;     // one-cycle pulse on btn_out 0->1
  logic [4:0] fall;     // one-cycle pulse on btn_out 1->0

  modport master (
    output btn_in,
    input  btn_out,
    input  rise,
    input  fall
  );

  modport slave (
    input  btn_in,
    output btn_out,
    output rise,
    output fall
  );
endinterface

// File: rtl/xup_debounce5.sv
// Five-channel synchroniser + debouncer. Each channel's raw input passes
// through a SYNC_STAGES flop chain, then a saturating qualification counter
// must see DEBOUNCE_CYCLES consecutive disagreeing samples before the stable
// level flips. The stable levels feed the five inputs of the 5-input OR cell;
// rise/fall pulses are issued on the same edge the level flips.
module xup_debounce5 #(
  parameter int DEBOUNCE_CYCLES = 1000000, // 1 .. 2**CNT_W
  parameter int CNT_W           = 20,      // 2**CNT_W >= DEBOUNCE_CYCLES
  parameter int SYNC_STAGES     = 2        // 2 .. 4
) (
  input  logic           clk,
  input  logic           reset_n,
  xup_debounce5_if.slave bus
);

  localparam int LP_NCH = 5;

  // Terminal count: the sample that reaches this value while still
  // disagreeing is the DEBOUNCE_CYCLES-th in a row, so the level flips.
  localparam logic [CNT_W-1:0] LP_CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LP_CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] LP_CNT_ZERO = CNT_W'(0);

  // Synchroniser chain: r_sync[0] samples the pins, the last stage is the
  // metastability-resolved view of each channel. Pure flop-to-flop.
  logic [LP_NCH-1:0] r_sync [SYNC_STAGES];

  // Per-channel qualification counters and registered outputs.
  logic [CNT_W-1:0]  r_cnt [LP_NCH];
  logic [LP_NCH-1:0] r_btn_out;
  logic [LP_NCH-1:0] r_rise;
  logic [LP_NCH-1:0] r_fall;

  // Next-state values computed combinationally, registered below.
  logic [LP_NCH-1:0] w_sync;
  logic [LP_NCH-1:0] w_diff;
  logic [CNT_W-1:0]  w_cnt_nxt [LP_NCH];
  logic [LP_NCH-1:0] w_out_nxt;
  logic [LP_NCH-1:0] w_rise_nxt;
  logic [LP_NCH-1:0] w_fall_nxt;

  assign w_sync = r_sync[SYNC_STAGES-1];
  assign w_diff = w_sync ^ r_btn_out;

  // Shift raw inputs through the synchroniser flops; cleared by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        r_sync[k] <= 5'b00000;
      end
    end else begin
      r_sync[0] <= bus.btn_in;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        r_sync[k] <= r_sync[k-1];
      end
    end
  end

  // Per-channel debounce decision: reset the count on agreement, count up on
  // disagreement, and flip the level (with a direction pulse) at terminal
  // count. A single matching sample wipes all accumulated credit.
  always_comb begin
    w_out_nxt  = r_btn_out;
    w_rise_nxt = 5'b00000;
    w_fall_nxt = 5'b00000;
    for (int i = 0; i < LP_NCH; i++) begin
      w_cnt_nxt[i] = r_cnt[i];
      if (!w_diff[i]) begin
        w_cnt_nxt[i] = LP_CNT_ZERO;
      end else if (r_cnt[i] == LP_CNT_MAX) begin
        w_cnt_nxt[i]  = LP_CNT_ZERO;
        w_out_nxt[i]  = w_sync[i];
        w_rise_nxt[i] = w_sync[i];
        w_fall_nxt[i] = ~w_sync[i];
      end else begin
        w_cnt_nxt[i] = r_cnt[i] + LP_CNT_ONE;
      end
    end
  end

  // Register counters, stable levels and edge pulses; pulses self-clear
  // because their next-state default is zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < LP_NCH; i++) begin
        r_cnt[i] <= LP_CNT_ZERO;
      end
      r_btn_out <= 5'b00000;
      r_rise    <= 5'b00000;
      r_fall    <= 5'b00000;
    end else begin
      for (int i = 0; i < LP_NCH; i++) begin
        r_cnt[i] <= w_cnt_nxt[i];
      end
      r_btn_out <= w_out_nxt;
      r_rise    <= w_rise_nxt;
      r_fall    <= w_fall_nxt;
    end
  end

  assign bus.btn_out = r_btn_out;
  assign bus.rise    = r_rise;
  assign bus.fall    = r_fall;

endmodule

// File: tb/tb_xup_debounce5.sv
// Bench for xup_debounce5: directed scenarios with explicit edge-count
// expectations, a randomized run against a sliding-window reference model,
// and a second instance exercising the DEBOUNCE_CYCLES = 1 corner.
module tb_xup_debounce5;

  localparam int D   = 4;
  localparam int SS  = 2;
  localparam int CW  = 3;
  localparam int SS1 = 3;

  logic clk;
  logic reset_n;
  int   n_vec;
  int   n_err;

  // Reference model: level flips when the last D synchronised samples all
  // disagree with it; synchronised sample = btn_in from SS edges earlier.
  logic [4:0] m_out;
  logic [4:0] m_rise;
  logic [4:0] m_fall;
  logic [4:0] m_pipe [$];
  logic [4:0] m_win  [$];

  xup_debounce5_if bus ();
  xup_debounce5_if bus1 ();

  xup_debounce5 #(.DEBOUNCE_CYCLES(D), .CNT_W(CW), .SYNC_STAGES(SS)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  xup_debounce5 #(.DEBOUNCE_CYCLES(1), .CNT_W(1), .SYNC_STAGES(SS1)) dut1 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic model_clear();
    m_out  = 5'b00000;
    m_rise = 5'b00000;
    m_fall = 5'b00000;
    m_pipe = {};
    m_win  = {};
    repeat (SS) m_pipe.push_back(5'b00000);
    repeat (D)  m_win.push_back(5'b00000);
  endtask

  // Advance one rising edge, update the model, leave time at edge + 1.
  task automatic tick();
    logic [4:0] s;
    bit all_diff;
    @(posedge clk);
    if (!reset_n) begin
      model_clear();
    end else begin
      s = m_pipe.pop_front();
      m_pipe.push_back(bus.btn_in);
      void'(m_win.pop_front());
      m_win.push_back(s);
      m_rise = 5'b00000;
      m_fall = 5'b00000;
      for (int i = 0; i < 5; i++) begin
        all_diff = 1'b1;
        foreach (m_win[k]) if (m_win[k][i] == m_out[i]) all_diff = 1'b0;
        if (all_diff) begin
          if (m_out[i]) m_fall[i] = 1'b1;
          else          m_rise[i] = 1'b1;
        end
      end
      m_out = m_out ^ (m_rise | m_fall);
    end
    #1;
  endtask

  task automatic test_reset();
    logic [4:0] eo;
    logic [4:0] er;
    reset_n = 1'b0;
    bus.btn_in  = 5'b11111;
    bus1.btn_in = 5'b00000;
    model_clear();
    for (int e = 1; e <= 4; e++) begin
      tick();
      n_vec++;
      if (bus.btn_out !== 5'b00000 || bus.rise !== 5'b00000 || bus.fall !== 5'b00000) begin
        n_err++;
        $display("FAIL reset_hold edge %0d: out=%b rise=%b fall=%b, expected all 0", e, bus.btn_out, bus.rise, bus.fall);
      end
    end
    reset_n = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick();
      eo = (e >= 6) ? 5'b11111 : 5'b00000;
      er = (e == 6) ? 5'b11111 : 5'b00000;
      n_vec++;
      if (bus.btn_out !== eo || bus.rise !== er || bus.fall !== 5'b00000) begin
        n_err++;
        $display("FAIL reset_release edge %0d: out=%b rise=%b fall=%b, expected %b %b 00000", e, bus.btn_out, bus.rise, bus.fall, eo, er);
      end
    end
  endtask

  task automatic test_clean_press();
    logic [4:0] eo;
    logic [4:0] er;
    logic [4:0] ef;
    bus.btn_in = 5'b00000;
    repeat (10) tick();
    n_vec++;
    if (bus.btn_out !== 5'b00000) begin
      n_err++;
      $display("FAIL press_idle: out=%b, expected 00000", bus.btn_out);
    end
    bus.btn_in = 5'b00100;
    for (int e = 1; e <= 8; e++) begin
      tick();
      eo = (e >= 6) ? 5'b00100 : 5'b00000;
      er = (e == 6) ? 5'b00100 : 5'b00000;
      n_vec++;
      if (bus.btn_out !== eo || bus.rise !== er || bus.fall !== 5'b00000) begin
        n_err++;
        $display("FAIL press edge %0d: out=%b rise=%b fall=%b, expected %b %b 00000", e, bus.btn_out, bus.rise, bus.fall, eo, er);
      end
    end
    bus.btn_in = 5'b00000;
    for (int e = 1; e <= 8; e++) begin
      tick();
      eo = (e >= 6) ? 5'b00000 : 5'b00100;
      ef = (e == 6) ? 5'b00100 : 5'b00000;
      n_vec++;
      if (bus.btn_out !== eo || bus.rise !== 5'b00000 || bus.fall !== ef) begin
        n_err++;
        $display("FAIL release edge %0d: out=%b rise=%b fall=%b, expected %b 00000 %b", e, bus.btn_out, bus.rise, bus.fall, eo, ef);
      end
    end
  endtask

  task automatic test_glitch();
    int n_r;
    int n_f;
    for (int t = 1; t <= 13; t++) begin
      bus.btn_in = (t <= 3) ? 5'b00001 : 5'b00000;
      tick();
      n_vec++;
      if (bus.btn_out !== 5'b00000 || bus.rise !== 5'b00000 || bus.fall !== 5'b00000) begin
        n_err++;
        $display("FAIL glitch3 tick %0d: out=%b rise=%b fall=%b, expected all 0", t, bus.btn_out, bus.rise, bus.fall);
      end
    end
    n_r = 0;
    n_f = 0;
    for (int t = 1; t <= 16; t++) begin
      bus.btn_in = (t <= 4) ? 5'b00001 : 5'b00000;
      tick();
      if (bus.rise == 5'b00001) n_r++;
      if (bus.fall == 5'b00001) n_f++;
      if (t == 6) begin
        n_vec++;
        if (bus.btn_out !== 5'b00001 || bus.rise !== 5'b00001) begin
          n_err++;
          $display("FAIL glitch4_rise: out=%b rise=%b, expected 00001 00001", bus.btn_out, bus.rise);
        end
      end
      if (t == 10) begin
        n_vec++;
        if (bus.btn_out !== 5'b00000 || bus.fall !== 5'b00001) begin
          n_err++;
          $display("FAIL glitch4_fall: out=%b fall=%b, expected 00000 00001", bus.btn_out, bus.fall);
        end
      end
    end
    n_vec++;
    if (n_r != 1 || n_f != 1) begin
      n_err++;
      $display("FAIL glitch4_count: rises=%0d falls=%0d, expected 1 1", n_r, n_f);
    end
  endtask

  task automatic test_bounce();
    logic [5:0] seq;
    int n_r;
    int n_f;
    int t_r;
    seq = 6'b101101; // applied LSB first: 1,0,1,1,0,1
    n_r = 0;
    n_f = 0;
    t_r = 0;
    for (int t = 1; t <= 16; t++) begin
      bus.btn_in = (t <= 6) ? {seq[t-1], 4'b0000} : 5'b10000;
      tick();
      if (bus.rise != 5'b00000) begin
        n_r++;
        t_r = t;
      end
      if (bus.fall != 5'b00000) n_f++;
    end
    n_vec++;
    if (n_r != 1 || n_f != 0 || t_r != 11 || bus.btn_out !== 5'b10000) begin
      n_err++;
      $display("FAIL bounce: rises=%0d at tick %0d falls=%0d out=%b, expected 1 at 11, 0, 10000", n_r, t_r, n_f, bus.btn_out);
    end
  endtask

  task automatic test_parallel();
    logic [4:0] eo;
    logic [4:0] er;
    bus.btn_in = 5'b00000;
    repeat (10) tick();
    bus.btn_in = 5'b10101;
    for (int e = 1; e <= 8; e++) begin
      tick();
      eo = (e >= 6) ? 5'b10101 : 5'b00000;
      er = (e == 6) ? 5'b10101 : 5'b00000;
      n_vec++;
      if (bus.btn_out !== eo || bus.rise !== er || bus.fall !== 5'b00000) begin
        n_err++;
        $display("FAIL parallel edge %0d: out=%b rise=%b fall=%b, expected %b %b 00000", e, bus.btn_out, bus.rise, bus.fall, eo, er);
      end
    end
  endtask

  task automatic test_reset_midcount();
    logic [4:0] eo;
    logic [4:0] er;
    bus.btn_in = 5'b01010;
    repeat (4) tick();
    n_vec++;
    if (bus.btn_out !== 5'b10101) begin
      n_err++;
      $display("FAIL midcount_pre: out=%b, expected 10101", bus.btn_out);
    end
    reset_n = 1'b0;
    model_clear();
    #1;
    n_vec++;
    if (bus.btn_out !== 5'b00000 || bus.rise !== 5'b00000 || bus.fall !== 5'b00000) begin
      n_err++;
      $display("FAIL midcount_async: out=%b rise=%b fall=%b, expected all 0", bus.btn_out, bus.rise, bus.fall);
    end
    repeat (2) tick();
    reset_n = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick();
      eo = (e >= 6) ? 5'b01010 : 5'b00000;
      er = (e == 6) ? 5'b01010 : 5'b00000;
      n_vec++;
      if (bus.btn_out !== eo || bus.rise !== er || bus.fall !== 5'b00000) begin
        n_err++;
        $display("FAIL midcount_release edge %0d: out=%b rise=%b fall=%b, expected %b %b 00000", e, bus.btn_out, bus.rise, bus.fall, eo, er);
      end
    end
  endtask

  task automatic test_random();
    int len;
    for (int seg = 0; seg < 80; seg++) begin
      bus.btn_in = 5'($urandom_range(0, 31));
      len = $urandom_range(1, 7);
      for (int t = 0; t < len; t++) begin
        tick();
        n_vec++;
        if (bus.btn_out !== m_out || bus.rise !== m_rise || bus.fall !== m_fall || (bus.rise & bus.fall) !== 5'b00000) begin
          n_err++;
          $display("FAIL random seg %0d: out=%b rise=%b fall=%b, expected %b %b %b", seg, bus.btn_out, bus.rise, bus.fall, m_out, m_rise, m_fall);
        end
      end
    end
  endtask

  task automatic test_single_cycle();
    logic [4:0] q [$];
    logic [4:0] s;
    logic [4:0] prev;
    bus1.btn_in = 5'b00000;
    repeat (8) tick();
    q = {};
    repeat (SS1) q.push_back(5'b00000);
    prev = 5'b00000;
    for (int t = 0; t < 60; t++) begin
      bus1.btn_in = 5'($urandom_range(0, 31));
      tick();
      s = q.pop_front();
      q.push_back(bus1.btn_in);
      n_vec++;
      if (bus1.btn_out !== s || bus1.rise !== (s & ~prev) || bus1.fall !== (~s & prev)) begin
        n_err++;
        $display("FAIL single_cycle t %0d: out=%b rise=%b fall=%b, expected %b %b %b", t, bus1.btn_out, bus1.rise, bus1.fall, s, s & ~prev, ~s & prev);
      end
      prev = s;
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_clean_press();
    test_glitch();
    test_bounce();
    test_parallel();
    test_reset_midcount();
    test_random();
    test_single_cycle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/xup_debounce5.md
Name: xup_debounce5

Overview:
- Five-channel synchroniser and debouncer for the Basys3 push-buttons or switches.
- Produces clean, glitch-free levels that drive the five inputs a..e of the 5-input OR gate library cell, forming an "any button active" signal.
- Also emits one-cycle rise and fall pulses per channel for edge-driven logic.
- Channel count is fixed at 5 to match the OR cell.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive clk cycles a synchronised input must differ from the current stable level before that level flips (10 ms at 100 MHz); legal range 1..2^CNT_W.
- CNT_W, 20, width of each per-channel counter; must satisfy 2^CNT_W >= DEBOUNCE_CYCLES.
- SYNC_STAGES, 2, flip-flop stages in each input synchroniser; legal range 2..4.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- btn_in  input  5  raw asynchronous inputs, bit i = channel i.
- btn_out  output  5  debounced stable levels; bit i feeds OR input i (a=bit0 .. e=bit4).
- rise  output  5  one-cycle pulse when btn_out[i] goes 0->1.
- fall  output  5  one-cycle pulse when btn_out[i] goes 1->0.

Behaviour:
- Reset (reset_n low, asynchronous assert): all synchroniser flops, counters, btn_out, rise and fall are cleared to 0 immediately. Release is sampled on the next rising clk edge.
- Channels are fully independent, with identical logic per bit.
- Synchroniser: btn_in[i] passes through SYNC_STAGES flops to give s[i]. No logic sits between stages.
- Per-channel counter cnt[i] (CNT_W bits), evaluated on each rising edge:
  - s[i] == btn_out[i]: cnt[i] <= 0.
  - s[i] != btn_out[i] and cnt[i] < DEBOUNCE_CYCLES-1: cnt[i] <= cnt[i]+1.
  - s[i] != btn_out[i] and cnt[i] == DEBOUNCE_CYCLES-1: btn_out[i] <= s[i], cnt[i] <= 0, and rise[i] or fall[i] <= 1 according to direction.
- rise[i] and fall[i] are high for exactly one cycle and are 0 on every other cycle. They are never both high.
- Latency: call the rising edge that first samples a new btn_in level edge 1. If the level is held, btn_out changes on edge SYNC_STAGES + DEBOUNCE_CYCLES (edge 6 for SYNC_STAGES=2, DEBOUNCE_CYCLES=4). rise/fall assert on the same edge.
- Glitch rejection: a synchronised deviation shorter than DEBOUNCE_CYCLES cycles never changes btn_out. The counter returns to 0 on the first matching cycle, with no partial credit carried over.
- DEBOUNCE_CYCLES = 1: btn_out follows s with one extra cycle of delay, and every change pulses.
- Counter never wraps: its maximum value is DEBOUNCE_CYCLES-1.
- Reset mid-count discards the count. After release, btn_out is 0, so an input held high re-qualifies from scratch and produces a rise pulse.
- Simultaneous changes on several channels are processed in parallel with no arbitration. Multiple rise/fall bits may be high in the same cycle.
- No combinational path from btn_in to any output; all outputs are registered.

Test Plan:
- Reset values (SYNC_STAGES=2, DEBOUNCE_CYCLES=4): btn_in=5'b11111 with reset_n low -> btn_out=0, rise=0, fall=0 throughout reset. Release reset, hold input -> btn_out=5'b11111 and rise=5'b11111 for one cycle on edge 6 after release, then rise=0.
- Clean press: btn_in[2] 0->1 held -> btn_out[2]=1 at edge 6, rise=5'b00100 for exactly that cycle, other bits 0. Then release to 0 -> fall=5'b00100 one cycle at edge 6, btn_out[2]=0.
- Glitch rejection: btn_in[0] high for 3 cycles then low -> btn_out[0] stays 0, no rise pulse. Repeat with 4 cycles high -> btn_out[0]=1 then later 0, with one rise and one fall pulse.
- Bounce: btn_in[4] toggles 1,0,1,1,0,1 then holds 1 -> exactly one rise pulse, issued 6 edges after the final 0->1 transition; no fall pulse.
- Parallel and reset mid-count: btn_in=5'b10101 simultaneously -> rise=5'b10101 in one cycle. Separately, assert reset_n low while cnt=2 mid-count -> outputs 0 immediately. After release with input held high, rise fires 6 edges later.
